// File: rtl/bp_trace_sequencer.sv
// Replays a stored branch trace into a one-bit branch predictor and tallies its misses.
// Trace RAM: async read, sync write; all outputs registered.
module bp_trace_sequencer #(
    parameter int ID_W         = 3,
    parameter int ADDR_W       = 6,
    parameter int CNT_W        = 16,
    parameter int MISS_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ID_W-1:0]   wr_id,
    input  logic              wr_outcome,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    output logic              bp_reset,
    output logic [ID_W-1:0]   bp_branch_id,
    output logic              bp_outcome,
    output logic              bp_valid,
    input  logic              bp_miss,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  issued_count,
    output logic [2:0]        dbg_state
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DW    = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY + 1) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, next_state;

    logic [ID_W:0]           ram [DEPTH];
    logic [ADDR_W-1:0]       rd_ptr;
    logic [ADDR_W:0]         left;
    logic [DW-1:0]           drain_left;
    logic [MISS_LATENCY-1:0] valid_sr;
    logic                    miss_en;
    logic                    idle_like;
    logic                    start_ok;
    logic [ADDR_W:0]         len_clamped;

    assign idle_like   = (state == S_IDLE) || (state == S_DONE);
    assign start_ok    = idle_like && start;
    assign len_clamped = (length > DEPTH_L) ? DEPTH_L : length;
    assign miss_en     = valid_sr[MISS_LATENCY-1];
    assign dbg_state   = state;

    // A write coinciding with an accepted start is dropped so the run sees pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en && idle_like && !start) begin
            ram[wr_addr] <= {wr_id, wr_outcome};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_CLEAR;
            S_CLEAR: next_state = (left == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (left == '0) next_state = S_DRAIN;
            S_DRAIN: if (drain_left == '0) next_state = S_DONE;
            S_DONE:  if (start) next_state = S_CLEAR;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_reset     <= 1'b1;
            bp_branch_id <= '0;
            bp_outcome   <= 1'b0;
            bp_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            miss_count   <= '0;
            issued_count <= '0;
            rd_ptr       <= '0;
            left         <= '0;
            drain_left   <= '0;
            valid_sr     <= '0;
        end else begin
            // Status outputs are registered from the state being entered.
            bp_reset <= (next_state == S_IDLE) || (next_state == S_CLEAR);
            busy     <= (next_state == S_CLEAR) || (next_state == S_ISSUE) ||
                        (next_state == S_DRAIN);
            done     <= (next_state == S_DONE);
            bp_valid <= (next_state == S_ISSUE);

            valid_sr[0] <= bp_valid;
            for (int i = 1; i < MISS_LATENCY; i++) begin
                valid_sr[i] <= valid_sr[i-1];
            end

            if (start_ok) begin
                rd_ptr       <= '0;
                left         <= len_clamped;
                miss_count   <= '0;
                issued_count <= '0;
            end else begin
                if (next_state == S_ISSUE) begin
                    {bp_branch_id, bp_outcome} <= ram[rd_ptr];
                    rd_ptr <= rd_ptr + 1'b1;
                    left   <= left - 1'b1;
                    if (issued_count != '1) issued_count <= issued_count + 1'b1;
                end
                if (state == S_ISSUE && next_state == S_DRAIN) begin
                    drain_left <= DW'(MISS_LATENCY - 1);
                end else if (state == S_DRAIN && drain_left != '0) begin
                    drain_left <= drain_left - 1'b1;
                end
                if (miss_en && bp_miss && miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bp_trace_sequencer.sv
// Directed bench: a behavioural one-bit predictor answers the sequencer; run timing and totals are checked.
module tb_bp_trace_sequencer;
    localparam int ID_W   = 3;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ID_W-1:0]   wr_id;
    logic              wr_outcome;
    logic              start;
    logic [ADDR_W:0]   length;
    logic              bp_reset;
    logic [ID_W-1:0]   bp_branch_id;
    logic              bp_outcome;
    logic              bp_valid;
    logic              bp_miss;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  miss_count;
    logic [CNT_W-1:0]  issued_count;
    logic [2:0]        dbg_state;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [ID_W-1:0] tr_id  [64];
    logic            tr_out [64];

    bp_trace_sequencer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_id(wr_id),
        .wr_outcome(wr_outcome), .start(start), .length(length), .bp_reset(bp_reset),
        .bp_branch_id(bp_branch_id), .bp_outcome(bp_outcome), .bp_valid(bp_valid),
        .bp_miss(bp_miss), .busy(busy), .done(done), .miss_count(miss_count),
        .issued_count(issued_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // One-bit predictor, miss one cycle after sampling; drives 1 whenever its miss is not valid.
    logic [7:0] bht;
    logic       pm;
    logic       vd;
    always @(posedge clk) begin
        if (bp_reset) begin
            bht <= '0;
            pm  <= 1'b0;
            vd  <= 1'b0;
        end else begin
            vd <= bp_valid;
            if (bp_valid) begin
                pm <= (bht[bp_branch_id] != bp_outcome);
                bht[bp_branch_id] <= bp_outcome;
            end
        end
    end
    assign bp_miss = vd ? pm : 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int id, input bit outcome);
        wr_en      = 1'b1;
        wr_addr    = ADDR_W'(addr);
        wr_id      = ID_W'(id);
        wr_outcome = outcome;
        tick();
        wr_en = 1'b0;
        tr_id[addr]  = ID_W'(id);
        tr_out[addr] = outcome;
    endtask

    task automatic run(input int len_in, input int exp_miss, input bit disturb);
        int eff;
        int done_c;
        int idx;
        eff    = (len_in > 64) ? 64 : len_in;
        done_c = (eff == 0) ? 2 : eff + 3;
        length = (ADDR_W + 1)'(len_in);
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= done_c; c++) begin
            chk($sformatf("bp_reset_c%0d", c), 32'(bp_reset), 32'(c == 1));
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c < done_c));
            chk($sformatf("done_c%0d", c), 32'(done), 32'(c == done_c));
            chk($sformatf("valid_c%0d", c), 32'(bp_valid), 32'(c >= 2 && c <= eff + 1));
            if (c == 1) begin
                chk("miss_cnt_cycle1", 32'(miss_count), 32'd0);
                chk("issued_cnt_cycle1", 32'(issued_count), 32'd0);
            end
            if (c >= 2 && c <= eff + 1) begin
                idx = (c - 2) % 64;
                chk($sformatf("id_c%0d", c), 32'(bp_branch_id), 32'(tr_id[idx]));
                chk($sformatf("out_c%0d", c), 32'(bp_outcome), 32'(tr_out[idx]));
            end
            if (disturb && c == 3) begin
                start      = 1'b1;
                wr_en      = 1'b1;
                wr_addr    = '0;
                wr_id      = 3'd7;
                wr_outcome = 1'b0;
            end
            if (disturb && c == 4) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (c < done_c) tick();
        end
        chk("miss_count", 32'(miss_count), 32'(exp_miss));
        chk("issued_count", 32'(issued_count), 32'(eff));
        tick();
        chk("done_sticky", 32'(done), 32'd1);
        chk("miss_frozen", 32'(miss_count), 32'(exp_miss));
        chk("issued_frozen", 32'(issued_count), 32'(eff));
        chk("valid_after_done", 32'(bp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_id      = '0;
        wr_outcome = 1'b0;
        start      = 1'b0;
        length     = '0;
        tick();
        tick();
        chk("rst_bp_reset", 32'(bp_reset), 32'd1);
        chk("rst_valid", 32'(bp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        chk("rst_issued", 32'(issued_count), 32'd0);
        chk("rst_id", 32'(bp_branch_id), 32'd0);
        chk("rst_out", 32'(bp_outcome), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_bp_reset", 32'(bp_reset), 32'd1);

        write_entry(0, 0, 1'b1);
        write_entry(1, 0, 1'b1);
        write_entry(2, 0, 1'b0);
        write_entry(3, 1, 1'b0);

        run(4, 2, 1'b0);
        run(4, 2, 1'b0);
        run(0, 0, 1'b0);
        run(4, 2, 1'b1);
        run(4, 2, 1'b0);

        for (int i = 0; i < 64; i++) write_entry(i, 5, (i % 2) == 0);
        run(64, 64, 1'b0);
        run(100, 64, 1'b0);

        length = 7'd4;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_miss", 32'(miss_count), 32'd0);
        chk("abort_issued", 32'(issued_count), 32'd0);
        chk("abort_bp_reset", 32'(bp_reset), 32'd1);
        chk("abort_valid", 32'(bp_valid), 32'd0);
        reset = 1'b0;
        tick();
        run(4, 4, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
